// File: rtl/e_mdu_pkg.sv
// Shared MDU definitions: op encodings, latency constants and FSM state type,
// imported by the E-stage MDU, the E-stage controller and the hazard unit.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } mdu_op_e;

  localparam int unsigned MULT_LATENCY = 5;
  localparam int unsigned DIV_LATENCY  = 10;

  // The counter runs down to zero inclusive, so it loads latency-1.
  localparam logic [3:0] MULT_CNT_LOAD = 4'(MULT_LATENCY - 1);
  localparam logic [3:0] DIV_CNT_LOAD  = 4'(DIV_LATENCY - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_long_op(input logic [3:0] op_in);
    logic long_s;
    case (op_in)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: long_s = 1'b1;
      default:                            long_s = 1'b0;
    endcase
    return long_s;
  endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed-latency MULT/DIV with HI/LO registers,
// MFHI/MFLO read port and a stall request towards the hazard unit.
module e_mdu
  import e_mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] E_rs,
  input  logic [31:0] E_rt,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_out
);

  mdu_state_e  state_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] rs_q;
  logic [31:0] rt_q;
  logic [3:0]  op_q;

  logic [63:0] rs_ext_d;
  logic [63:0] rt_ext_d;
  logic [63:0] prod_d;
  logic        div_signed_d;
  logic        rs_neg_d;
  logic        rt_neg_d;
  logic [31:0] rs_abs_d;
  logic [31:0] rt_abs_d;
  logic [31:0] divisor_d;
  logic [31:0] uquot_d;
  logic [31:0] urem_d;
  logic [31:0] quot_d;
  logic [31:0] rem_d;
  logic [31:0] res_hi_d;
  logic [31:0] res_lo_d;
  logic        res_wr_d;

  // Result datapath from the latched operands; only sampled at completion.
  always_comb begin
    if (op_q == OP_MULT) begin
      rs_ext_d = {{32{rs_q[31]}}, rs_q};
      rt_ext_d = {{32{rt_q[31]}}, rt_q};
    end else begin
      rs_ext_d = {32'd0, rs_q};
      rt_ext_d = {32'd0, rt_q};
    end
    prod_d = rs_ext_d * rt_ext_d;

    // Signed division is done on magnitudes so INT_MIN / -1 wraps to INT_MIN
    // with a zero remainder instead of overflowing.
    div_signed_d = (op_q == OP_DIV);
    rs_neg_d     = div_signed_d & rs_q[31];
    rt_neg_d     = div_signed_d & rt_q[31];
    rs_abs_d     = rs_neg_d ? (32'd0 - rs_q) : rs_q;
    rt_abs_d     = rt_neg_d ? (32'd0 - rt_q) : rt_q;
    divisor_d    = (rt_q == 32'd0) ? 32'd1 : rt_abs_d;
    uquot_d      = rs_abs_d / divisor_d;
    urem_d       = rs_abs_d % divisor_d;
    quot_d       = (rs_neg_d ^ rt_neg_d) ? (32'd0 - uquot_d) : uquot_d;
    rem_d        = rs_neg_d ? (32'd0 - urem_d) : urem_d;

    case (op_q)
      OP_MULT, OP_MULTU: begin
        res_hi_d = prod_d[63:32];
        res_lo_d = prod_d[31:0];
        res_wr_d = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        res_hi_d = rem_d;
        res_lo_d = quot_d;
        res_wr_d = (rt_q != 32'd0);
      end
      default: begin
        res_hi_d = 32'd0;
        res_lo_d = 32'd0;
        res_wr_d = 1'b0;
      end
    endcase
  end

  // Control FSM, operand latches and HI/LO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      rs_q    <= 32'd0;
      rt_q    <= 32'd0;
      op_q    <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                state_q <= ST_RUN;
                busy_q  <= 1'b1;
                cnt_q   <= MULT_CNT_LOAD;
                rs_q    <= E_rs;
                rt_q    <= E_rt;
                op_q    <= op;
              end
              OP_DIV, OP_DIVU: begin
                state_q <= ST_RUN;
                busy_q  <= 1'b1;
                cnt_q   <= DIV_CNT_LOAD;
                rs_q    <= E_rs;
                rt_q    <= E_rt;
                op_q    <= op;
              end
              OP_MTHI: hi_q <= E_rs;
              OP_MTLO: lo_q <= E_rs;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          // Starts arriving while running are deliberately not looked at.
          if (cnt_q == 4'd0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            if (res_wr_d) begin
              hi_q <= res_hi_d;
              lo_q <= res_lo_d;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  // Read port for MFHI/MFLO into the E-stage result mux.
  always_comb begin
    case (op)
      OP_MFHI: mdu_out = hi_q;
      OP_MFLO: mdu_out = lo_q;
      default: mdu_out = 32'd0;
    endcase
  end

  assign stall_req = busy_q | (start & is_long_op(op));
  assign busy      = busy_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: arithmetic reference model compared every
// cycle, plus directed vectors with hand-computed literal results.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [31:0] E_rs;
  logic [31:0] E_rt;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdu_out;

  always #5 clk = ~clk;

  e_mdu dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .E_rs(E_rs), .E_rt(E_rt),
    .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo), .mdu_out(mdu_out)
  );

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {write_enable, hi, lo} from plain 64-bit arithmetic.
  function automatic logic [64:0] ref_result(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] up;
    logic [63:0] sp;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      4'd1: begin sp = sa * sb; return {1'b1, sp}; end
      4'd2: begin up = {32'd0, a} * {32'd0, b}; return {1'b1, up}; end
      4'd3: begin
        if (b == 32'd0) return {1'b0, 64'd0};
        sq = sa / sb;
        sr = sa % sb;
        return {1'b1, sr[31:0], sq[31:0]};
      end
      4'd4: begin
        if (b == 32'd0) return {1'b0, 64'd0};
        return {1'b1, a % b, a / b};
      end
      default: return {1'b0, 64'd0};
    endcase
  endfunction

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [64:0] m_pend = 65'd0;
  int          m_left = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
      m_left <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1 && m_pend[64]) begin
        m_hi <= m_pend[63:32];
        m_lo <= m_pend[31:0];
      end
    end else if (start) begin
      if (op >= 4'd1 && op <= 4'd4) begin
        m_pend <= ref_result(op, E_rs, E_rt);
        m_left <= (op <= 4'd2) ? 5 : 10;
      end else if (op == 4'd7) begin
        m_hi <= E_rs;
      end else if (op == 4'd8) begin
        m_lo <= E_rs;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("cyc_busy", {31'd0, busy}, {31'd0, m_left > 0});
      check("cyc_hi", hi, m_hi);
      check("cyc_lo", lo, m_lo);
      check("cyc_stall", {31'd0, stall_req},
            {31'd0, (m_left > 0) || (start && op >= 4'd1 && op <= 4'd4)});
      check("cyc_mdu_out", mdu_out, (op == 4'd5) ? m_hi : ((op == 4'd6) ? m_lo : 32'd0));
    end
  end

  task automatic cyc(input logic s, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    start = s;
    op    = o;
    E_rs  = a;
    E_rt  = b;
    @(posedge clk);
    #2;
  endtask

  // Accept a long op and count the cycles busy stays high (bounded).
  task automatic run_long(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, output int n);
    cyc(1'b1, o, a, b);
    n = 0;
    while (busy && n < 20) begin
      n++;
      cyc(1'b0, 4'd0, 32'd0, 32'd0);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; op = 4'd0; E_rs = 32'd0; E_rt = 32'd0;
    @(posedge clk);
    #2;
    checking = 1'b1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    rst = 1'b0;

    run_long(4'd1, 32'hFFFFFFFE, 32'd3, n);
    check("mult_lat", n, 32'd5);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFA);
    check("model_mult_lo", m_lo, 32'hFFFFFFFA);

    run_long(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
    check("multu_lat", n, 32'd5);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);

    run_long(4'd3, 32'hFFFFFFF9, 32'd2, n);
    check("div_lat", n, 32'd10);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);
    check("model_div_hi", m_hi, 32'hFFFFFFFF);

    run_long(4'd3, 32'h80000000, 32'hFFFFFFFF, n);
    check("divmin_lo", lo, 32'h80000000);
    check("divmin_hi", hi, 32'h00000000);

    run_long(4'd4, 32'd100, 32'd7, n);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    cyc(1'b1, 4'd7, 32'hAAAA0000, 32'd0);
    cyc(1'b1, 4'd8, 32'h00005555, 32'd0);
    run_long(4'd4, 32'd7, 32'd0, n);
    check("div0_lat", n, 32'd10);
    check("div0_hi", hi, 32'hAAAA0000);
    check("div0_lo", lo, 32'h00005555);

    // MTLO, then MULT with start held through busy, then MFLO.
    cyc(1'b1, 4'd8, 32'h12345678, 32'd0);
    cyc(1'b1, 4'd1, 32'd3, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("held_stall", {31'd0, stall_req}, 32'd1);
      check("held_lo", lo, 32'h12345678);
      case (i)
        0:       cyc(1'b1, 4'd8, 32'hDEADBEEF, 32'd0);
        1:       cyc(1'b1, 4'd2, 32'd9, 32'd9);
        2:       cyc(1'b1, 4'd3, 32'd50, 32'd5);
        default: cyc(1'b1, 4'd7, 32'hCAFEF00D, 32'd0);
      endcase
    end
    check("held_busy_last", {31'd0, busy}, 32'd1);
    cyc(1'b1, 4'd8, 32'hDEADBEEF, 32'd0);
    check("held_done_busy", {31'd0, busy}, 32'd0);
    check("held_done_lo", lo, 32'd12);
    check("held_done_hi", hi, 32'd0);
    start = 1'b1; op = 4'd6; E_rs = 32'd0; E_rt = 32'd0;
    #1;
    check("mflo_out", mdu_out, 32'd12);
    cyc(1'b1, 4'd6, 32'd0, 32'd0);

    // Reset in the middle of a DIV aborts it with no write.
    cyc(1'b1, 4'd7, 32'h00001111, 32'd0);
    cyc(1'b1, 4'd8, 32'h00002222, 32'd0);
    cyc(1'b1, 4'd3, 32'd100, 32'd3);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'd0, 32'd0, 32'd0);
    rst = 1'b1;
    cyc(1'b1, 4'd7, 32'h0000BEEF, 32'd0);
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    for (int i = 0; i < 12; i++) cyc(1'b0, 4'd0, 32'd0, 32'd0);
    check("abort_late_hi", hi, 32'd0);
    check("abort_late_lo", lo, 32'd0);

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
